seq_mult_unit: RTL and testbench

//   Parametrised multi-cycle shift-add multiplier: the HI/LO execution unit for the CPU's MULT/MULTU.

---
 rtl/seq_mult_unit.sv | 121 ++++++++++++
 tb/tb_seq_mult_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - multi-cycle shift-add HI/LO multiplier for MULT/MULTU
// Optional macro MULT_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier is zero.
module seq_mult_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     mplier_shr;
  logic                 last_step;

  // Magnitude of the most negative value wraps to itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a      = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    mag_b      = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
    partial    = mplier_q[0] ? mcand_q : '0;
    acc_sum    = acc_q + partial;
    product    = neg_q ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
    mplier_shr = mplier_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
    last_step  = (count_q == CNT_W'(WIDTH - 1)) || (mplier_shr == '0);
`else
    last_step  = (count_q == CNT_W'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // The multiplicand register is pre-shifted each step, standing in for mcand << count.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        count_d  = count_q + CNT_W'(1);
        if (last_step) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = product;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - table-driven bench for seq_mult_unit (WIDTH=32)
module tb_seq_mult_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         Reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_res = '0;

  seq_mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .Reset(Reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_run(input bit s, input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic [W-1:0] m;
    int p;
    m = (s && b[W-1]) ? (~b + 32'd1) : b;
    p = -1;
    for (int i = 0; i < W; i++) if (m[i]) p = i;
    return (p + 1 < 1) ? 1 : p + 1;
`else
    return W;
`endif
  endfunction

  // Called at a falling edge; the next rising edge samples start, then operands are scrambled.
  task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(output int n, output bit ok, output bit held);
    n = 0; ok = 1'b0; held = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      if (busy) n++;
      if ({hi, lo} !== last_res) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string name, input int exp_n,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n; bit ok; bit held;
    wait_done(n, ok, held);
    check({name, "_timeout"}, 64'(ok), 64'd1);
    if (ok) begin
      check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
      check({name, "_held"}, 64'(held), 64'd1);
      check({name, "_busy_at_done"}, 64'(busy), 64'd0);
      check({name, "_hilo"}, {hi, lo}, {ehi, elo});
      last_res = {ehi, elo};
    end
  endtask

  initial begin
    int cnt;
    int ign_at;
    vecs[0]  = '{0, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
    vecs[1]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{1, 32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4]  = '{1, 32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[5]  = '{0, 32'd12345,    32'd1,        32'h0000_0000, 32'd12345};
    vecs[6]  = '{0, 32'hDEAD_BEEF, 32'd0,        32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{0, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[10] = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{1, 32'hFFFF_FFFF, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFB};

    Reset = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    Reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      launch(vecs[k].s, vecs[k].a, vecs[k].b);
      finish_op($sformatf("vec%0d", k), exp_run(vecs[k].s, vecs[k].b), vecs[k].ehi, vecs[k].elo);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", k), 64'(done), 64'd0);
      check($sformatf("vec%0d_hold_after", k), {hi, lo}, last_res);
    end

    // Start pulse mid-run must be ignored; a start in the done cycle chains the next op.
`ifdef MULT_EARLY_EXIT_EN
    ign_at = 2;
`else
    ign_at = 10;
`endif
    launch(1'b0, 32'd6, 32'd7);
    repeat (ign_at - 1) @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignore", exp_run(1'b0, 32'd7) - ign_at, 32'd0, 32'd42);
    launch(1'b0, 32'd9, 32'd9);
    finish_op("b2b", exp_run(1'b0, 32'd9), 32'd0, 32'd81);

    // Abort mid-run: outputs clear at once and no done pulse follows.
    @(negedge clk);
    launch(1'b0, 32'd3, 32'h8000_0000);
    repeat (14) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    Reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    Reset = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
